pipelined_barrel_shifter: RTL

//  Parametrised, fully pipelined barrel shifter: WIDTH-bit operand, log2(WIDTH)-bit shift amount.

---
 rtl/pipelined_barrel_shifter.sv | 106 ++++++++++
 1 files changed

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: one mux stage per shift-amount bit,
// valid/ready handshake with bubble-collapsing backpressure.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  parameter int LOG2W = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] I,
  input  logic [LOG2W-1:0] S,
  input  logic [1:0]       MODE,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] O,
  output logic             busy
);

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } mode_e;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       md,
    input int               n
  );
    logic [WIDTH-1:0] r;
    r = d;
    unique case (mode_e'(md))
      LSL: r = d << n;
      LSR: r = d >> n;
      ASR: r = WIDTH'($signed(d) >>> n);
      ROR: r = (d >> n) | (d << (WIDTH - n));
    endcase
    return r;
  endfunction

  logic [LOG2W-1:0] vld;
  logic [WIDTH-1:0] data [LOG2W];
  logic [1:0]       md   [LOG2W];
  logic [LOG2W-1:0] amt  [LOG2W];

  logic [LOG2W-1:0] rdy;
  logic [LOG2W-1:0] src_v;
  logic [WIDTH-1:0] src_d [LOG2W];
  logic [1:0]       src_m [LOG2W];
  logic [LOG2W-1:0] src_a [LOG2W];
  logic [WIDTH-1:0] stp   [LOG2W];

  logic [LOG2W-1:0] unused_amt;
  logic [1:0]       unused_md;

  for (genvar k = 0; k < LOG2W; k++) begin : g_stage
    // stage k frees up if it or any later stage is empty
    assign rdy[k] = out_ready | ~(&vld[LOG2W-1:k]);
    if (k == 0) begin : g_head
      assign src_v[k] = in_valid;
      assign src_d[k] = I;
      assign src_m[k] = MODE;
      assign src_a[k] = S;
    end else begin : g_body
      assign src_v[k] = vld[k-1];
      assign src_d[k] = data[k-1];
      assign src_m[k] = md[k-1];
      assign src_a[k] = amt[k-1];
    end
    assign stp[k] = src_a[k][k] ? step(src_d[k], src_m[k], 1 << k)
                                : src_d[k];
    assign unused_amt[k] = ^amt[k];
  end

  assign unused_md = md[LOG2W-1];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      vld <= '0;
      for (int k = 0; k < LOG2W; k++) begin
        data[k] <= '0;
        md[k]   <= '0;
        amt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < LOG2W; k++) begin
        if (rdy[k]) begin
          vld[k] <= src_v[k];
          if (src_v[k]) begin
            data[k] <= stp[k];
            md[k]   <= src_m[k];
            amt[k]  <= src_a[k];
          end
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = vld[LOG2W-1];
  assign O         = data[LOG2W-1];
  assign busy      = |vld;

endmodule
